// File: rtl/exu_fwd_bypass_unit_if.sv
// ID-stage operand bus between the issue logic and the forwarding/hazard unit.
// The master drives the instruction and stage results; the slave returns bypassed operands and stall.
interface exu_fwd_bypass_unit_if #(
   parameter int XLEN   = 64,
   parameter int NSRC   = 2,
   parameter int DEPTH  = 3,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) ();
   localparam int SELW = $clog2(DEPTH + 1);

   logic                   pipe_hold;
   logic                   flush;
   logic                   id_valid;
   logic [NSRC*REG_AW-1:0] id_rs_idx;
   logic [NSRC-1:0]        id_rs_used;
   logic [NSRC*XLEN-1:0]   id_rs_data;
   logic [REG_AW-1:0]      id_rd_idx;
   logic                   id_rd_wen;
   logic                   id_rd_late;
   logic [DEPTH*XLEN-1:0]  stage_data;
   logic [NSRC*XLEN-1:0]   fwd_src_data;
   logic [NSRC*SELW-1:0]   fwd_sel;
   logic                   stall;
   logic [CNT_W-1:0]       stall_cnt;

   modport master (
      output pipe_hold, flush, id_valid, id_rs_idx, id_rs_used, id_rs_data,
             id_rd_idx, id_rd_wen, id_rd_late, stage_data,
      input  fwd_src_data, fwd_sel, stall, stall_cnt
   );

   modport slave (
      input  pipe_hold, flush, id_valid, id_rs_idx, id_rs_used, id_rs_data,
             id_rd_idx, id_rd_wen, id_rd_late, stage_data,
      output fwd_src_data, fwd_sel, stall, stall_cnt
   );
endinterface

// File: rtl/exu_fwd_bypass_unit.sv
// Operand bypass and load-use hazard unit: shadows destination registers of in-flight
// instructions, forwards the youngest ready result and stalls ID on not-yet-ready producers.
module exu_fwd_bypass_unit #(
   parameter int XLEN       = 64,
   parameter int NSRC       = 2,
   parameter int DEPTH      = 3,
   parameter int REG_AW     = 5,
   parameter int LATE_STAGE = 1,
   parameter int CNT_W      = 32
) (
   input logic                  clk,
   input logic                  rst,
   exu_fwd_bypass_unit_if.slave bus
);
   localparam int SELW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0]     vld_q, vld_d;
   logic [DEPTH-1:0]     late_q, late_d;
   logic [REG_AW-1:0]    rd_q [DEPTH];
   logic [REG_AW-1:0]    rd_d [DEPTH];
   logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

   logic [NSRC-1:0]      need;
   logic [NSRC*SELW-1:0] sel;
   logic [NSRC*XLEN-1:0] data;
   logic [REG_AW-1:0]    rs;
   logic                 hit;
   logic                 stall;
   logic                 issue;

   // ID: per-source youngest-match search over the tracker, zero latency
   always_comb begin
      need = '0;
      sel  = '0;
      data = bus.id_rs_data;
      rs   = '0;
      hit  = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         rs  = bus.id_rs_idx[i*REG_AW +: REG_AW];
         hit = 1'b0;
         for (int k = 0; k < DEPTH; k++) begin
            if (!hit && vld_q[k] && (rd_q[k] == rs) && (rs != '0)) begin
               hit                  = 1'b1;
               sel[i*SELW +: SELW]  = SELW'(k + 1);
               data[i*XLEN +: XLEN] = bus.stage_data[k*XLEN +: XLEN];
               need[i]              = late_q[k] && (k < LATE_STAGE);
            end
         end
      end
   end

   assign stall = bus.id_valid & ~bus.flush & (|(bus.id_rs_used & need));
   assign issue = bus.id_valid & ~bus.flush & ~stall;

   // Tracker advance: a held pipe freezes both the shadow entries and the perf counter
   always_comb begin
      vld_d       = vld_q;
      late_d      = late_q;
      rd_d        = rd_q;
      stall_cnt_d = stall_cnt_q;
      if (!bus.pipe_hold) begin
         for (int k = DEPTH - 1; k > 0; k--) begin
            vld_d[k]  = vld_q[k-1];
            late_d[k] = late_q[k-1];
            rd_d[k]   = rd_q[k-1];
         end
         vld_d[0]  = issue && bus.id_rd_wen && (bus.id_rd_idx != '0);
         late_d[0] = bus.id_rd_late;
         rd_d[0]   = bus.id_rd_idx;
         if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q       <= '0;
         late_q      <= '0;
         stall_cnt_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            rd_q[k] <= '0;
         end
      end else begin
         vld_q       <= vld_d;
         late_q      <= late_d;
         rd_q        <= rd_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.fwd_src_data = data;
   assign bus.fwd_sel      = sel;
   assign bus.stall        = stall;
   assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_exu_fwd_bypass_unit.sv
// Bench for exu_fwd_bypass_unit: directed scenarios plus randomized traffic against an age-queue model.
module tb_exu_fwd_bypass_unit;
   localparam int XLEN       = 64;
   localparam int NSRC       = 2;
   localparam int DEPTH      = 3;
   localparam int REG_AW     = 5;
   localparam int LATE_STAGE = 1;
   localparam int CNT_W      = 4;
   localparam int SELW       = $clog2(DEPTH + 1);

   typedef struct packed {
      logic              vld;
      logic [REG_AW-1:0] rd;
      logic              late;
   } rec_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   exu_fwd_bypass_unit_if #(.XLEN(XLEN), .NSRC(NSRC), .DEPTH(DEPTH), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

   exu_fwd_bypass_unit #(
      .XLEN(XLEN), .NSRC(NSRC), .DEPTH(DEPTH), .REG_AW(REG_AW),
      .LATE_STAGE(LATE_STAGE), .CNT_W(CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic f, input logic h, input logic [4:0] rd,
                        input logic wen, input logic late, input logic [4:0] rs0,
                        input logic [4:0] rs1, input logic [1:0] used);
      bus.id_valid   = v;
      bus.flush      = f;
      bus.pipe_hold  = h;
      bus.id_rd_idx  = rd;
      bus.id_rd_wen  = wen;
      bus.id_rd_late = late;
      bus.id_rs_idx  = {rs1, rs0};
      bus.id_rs_used = used;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [SELW-1:0] sel_of(input int i);
      return bus.fwd_sel[i*SELW +: SELW];
   endfunction

   function automatic logic [XLEN-1:0] data_of(input int i);
      return bus.fwd_src_data[i*XLEN +: XLEN];
   endfunction

   task automatic test_reset();
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd5, 5'd7, 2'b11);
      #2;
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0h want=0", bus.stall); end
      total++; if (bus.fwd_sel !== '0) begin bad++; $display("FAIL reset_sel got=%0h want=0", bus.fwd_sel); end
      total++; if (bus.fwd_src_data !== bus.id_rs_data) begin bad++; $display("FAIL reset_data got=%0h want=%0h", bus.fwd_src_data, bus.id_rs_data); end
      total++; if (bus.stall_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bus.stall_cnt); end
   endtask

   task automatic test_ex_fwd();
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
      tick();
      bus.stage_data[0 +: XLEN] = 64'hA5;
      drive(1'b1, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0, 5'd5, 5'd0, 2'b11);
      #2;
      total++; if (sel_of(0) !== 2'd1) begin bad++; $display("FAIL ex_fwd_sel got=%0d want=1", sel_of(0)); end
      total++; if (data_of(0) !== 64'hA5) begin bad++; $display("FAIL ex_fwd_data got=%0h want=a5", data_of(0)); end
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL ex_fwd_stall got=%0h want=0", bus.stall); end
      bus.stage_data[0 +: XLEN] = 64'h1111;
   endtask

   task automatic test_priority();
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00); tick();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00); tick();
      drive(1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00); tick();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd7, 2'b10);
      #2;
      total++; if (sel_of(1) !== 2'd1) begin bad++; $display("FAIL prio_young_sel got=%0d want=1", sel_of(1)); end
      total++; if (data_of(1) !== 64'h1111) begin bad++; $display("FAIL prio_young_data got=%0h want=1111", data_of(1)); end
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00); tick();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00); tick();
      tick();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd7, 2'b10);
      #2;
      total++; if (sel_of(1) !== 2'd3) begin bad++; $display("FAIL prio_old_sel got=%0d want=3", sel_of(1)); end
      total++; if (data_of(1) !== 64'h3333) begin bad++; $display("FAIL prio_old_data got=%0h want=3333", data_of(1)); end
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); tick();
      drive(1'b1, 1'b0, 1'b0, 5'd10, 1'b0, 1'b0, 5'd9, 5'd0, 2'b01);
      #2;
      total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0h want=1", bus.stall); end
      total++; if (sel_of(0) !== 2'd1) begin bad++; $display("FAIL lu_sel_pending got=%0d want=1", sel_of(0)); end
      tick(); #2;
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL lu_release got=%0h want=0", bus.stall); end
      total++; if (sel_of(0) !== 2'd2) begin bad++; $display("FAIL lu_sel got=%0d want=2", sel_of(0)); end
      total++; if (data_of(0) !== 64'h2222) begin bad++; $display("FAIL lu_data got=%0h want=2222", data_of(0)); end
      total++; if (bus.stall_cnt !== 4'd1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", bus.stall_cnt); end
   endtask

   task automatic test_unused_src();
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); tick();
      drive(1'b1, 1'b0, 1'b0, 5'd10, 1'b0, 1'b0, 5'd9, 5'd9, 2'b00);
      #2;
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL unused_stall got=%0h want=0", bus.stall); end
      total++; if (bus.fwd_sel !== 4'b0101) begin bad++; $display("FAIL unused_sel got=%0h want=5", bus.fwd_sel); end
      tick(); #2;
      total++; if (bus.stall_cnt !== 4'd0) begin bad++; $display("FAIL unused_cnt got=%0d want=0", bus.stall_cnt); end
   endtask

   task automatic test_x0_flush();
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00); tick();
      drive(1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 5'd0, 5'd0, 2'b11);
      #2;
      total++; if (bus.fwd_sel !== '0) begin bad++; $display("FAIL x0_sel got=%0h want=0", bus.fwd_sel); end
      total++; if (bus.fwd_src_data !== bus.id_rs_data) begin bad++; $display("FAIL x0_data got=%0h want=%0h", bus.fwd_src_data, bus.id_rs_data); end
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); tick();
      drive(1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 5'd9, 5'd0, 2'b01);
      #2;
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%0h want=0", bus.stall); end
      tick();
      drive(1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 5'd9, 5'd0, 2'b01);
      #2;
      total++; if (sel_of(0) !== 2'd2) begin bad++; $display("FAIL flush_bubble_sel got=%0d want=2", sel_of(0)); end
      total++; if (bus.stall_cnt !== 4'd0) begin bad++; $display("FAIL flush_cnt got=%0d want=0", bus.stall_cnt); end
   endtask

   task automatic test_hold_reset();
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); tick();
      drive(1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0, 5'd9, 5'd0, 2'b01);
      for (int c = 0; c < 4; c++) begin
         #2;
         total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL hold_stall c=%0d got=%0h want=1", c, bus.stall); end
         total++; if (sel_of(0) !== 2'd1) begin bad++; $display("FAIL hold_sel c=%0d got=%0d want=1", c, sel_of(0)); end
         total++; if (bus.stall_cnt !== 4'd0) begin bad++; $display("FAIL hold_cnt c=%0d got=%0d want=0", c, bus.stall_cnt); end
         tick();
      end
      bus.pipe_hold = 1'b0;
      tick(); #2;
      total++; if (bus.stall_cnt !== 4'd1) begin bad++; $display("FAIL hold_release_cnt got=%0d want=1", bus.stall_cnt); end
      drive(1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); tick();
      drive(1'b1, 1'b0, 1'b0, 5'd10, 1'b0, 1'b0, 5'd9, 5'd0, 2'b01);
      #2;
      total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL rst_pre_stall got=%0h want=1", bus.stall); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #2;
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall got=%0h want=0", bus.stall); end
      total++; if (bus.stall_cnt !== 4'd0) begin bad++; $display("FAIL rst_mid_cnt got=%0d want=0", bus.stall_cnt); end
      total++; if (sel_of(0) !== 2'd0) begin bad++; $display("FAIL rst_mid_sel got=%0d want=0", sel_of(0)); end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int n = 1; n <= 20; n++) begin
         drive(1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); tick();
         drive(1'b1, 1'b0, 1'b0, 5'd10, 1'b0, 1'b0, 5'd9, 5'd0, 2'b01); tick(); tick();
         if (n == 10 || n == 20) begin
            #2;
            total++;
            if (bus.stall_cnt !== CNT_W'((n > 15) ? 15 : n)) begin
               bad++; $display("FAIL sat_cnt n=%0d got=%0d want=%0d", n, bus.stall_cnt, (n > 15) ? 15 : n);
            end
         end
      end
   endtask

   task automatic test_random();
      rec_t                 inflight[$];
      rec_t                 bubble;
      int                   m_cnt;
      logic                 v, f, h, wen, late, r_rst, e_stall, need;
      logic [4:0]           rd;
      logic [4:0]           rs [NSRC];
      logic [1:0]           used;
      logic [NSRC*SELW-1:0] e_sel;
      logic [NSRC*XLEN-1:0] e_data;
      bubble = '{vld: 1'b0, rd: '0, late: 1'b0};
      do_reset();
      inflight.delete();
      for (int a = 0; a < DEPTH; a++) inflight.push_back(bubble);
      m_cnt = 0;
      for (int c = 0; c < 500; c++) begin
         r_rst = ($urandom_range(0, 59) == 0);
         v     = ($urandom_range(0, 3) != 0);
         f     = ($urandom_range(0, 7) == 0);
         h     = ($urandom_range(0, 5) == 0);
         rd    = 5'($urandom_range(0, 3));
         wen   = 1'($urandom_range(0, 1));
         late  = 1'($urandom_range(0, 1));
         for (int i = 0; i < NSRC; i++) rs[i] = 5'($urandom_range(0, 3));
         used  = 2'($urandom_range(0, 3));
         bus.stage_data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         bus.id_rs_data = {$urandom(), $urandom(), $urandom(), $urandom()};
         drive(v, f, h, rd, wen, late, rs[0], rs[1], used);
         rst = r_rst;
         #2;
         e_stall = 1'b0;
         e_sel   = '0;
         e_data  = bus.id_rs_data;
         for (int i = 0; i < NSRC; i++) begin
            need = 1'b0;
            for (int a = 0; a < DEPTH; a++) begin
               if (inflight[a].vld && inflight[a].rd == rs[i] && rs[i] != 0) begin
                  e_sel[i*SELW +: SELW]  = SELW'(a + 1);
                  e_data[i*XLEN +: XLEN] = bus.stage_data[a*XLEN +: XLEN];
                  need = inflight[a].late && (a < LATE_STAGE);
                  break;
               end
            end
            if (used[i] && need && v && !f) e_stall = 1'b1;
         end
         total++; if (bus.stall !== e_stall) begin bad++; $display("FAIL rnd_stall c=%0d got=%0h want=%0h", c, bus.stall, e_stall); end
         total++; if (bus.fwd_sel !== e_sel) begin bad++; $display("FAIL rnd_sel c=%0d got=%0h want=%0h", c, bus.fwd_sel, e_sel); end
         total++; if (bus.fwd_src_data !== e_data) begin bad++; $display("FAIL rnd_data c=%0d got=%0h want=%0h", c, bus.fwd_src_data, e_data); end
         total++; if (bus.stall_cnt !== CNT_W'(m_cnt)) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d want=%0d", c, bus.stall_cnt, m_cnt); end
         tick();
         if (r_rst) begin
            for (int a = 0; a < DEPTH; a++) inflight[a] = bubble;
            m_cnt = 0;
         end else if (!h) begin
            if (e_stall && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (v && !f && !e_stall)
               inflight.push_front('{vld: (wen && rd != 0), rd: rd, late: late});
            else
               inflight.push_front(bubble);
            void'(inflight.pop_back());
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.stage_data = {64'h3333, 64'h2222, 64'h1111};
      bus.id_rs_data = {64'hBBBB, 64'hAAAA};
      drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
      tick();
      tick();
      rst = 1'b0;
      test_reset();
      test_ex_fwd();
      test_priority();
      test_load_use();
      test_unused_src();
      test_x0_flush();
      test_hold_reset();
      test_saturate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
